// File: rtl/int_ctrl.sv
// Interrupt controller with per-source edge/level mode, mask, W1C pending and priority ID.
// Optional macro INT_CTRL_SYNC_EN inserts a two-flop synchronizer on every irq_src bit.
module int_ctrl #(
    parameter int NSRC = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  irq_src,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [5:0]  HWInt
);

    localparam logic [6:0] SRC_ONE = 7'd1;
    localparam logic [5:0] SRC_EN  = 6'((SRC_ONE << NSRC) - SRC_ONE);

    logic [5:0] s;
    logic [5:0] prev;
    logic [5:0] mask;
    logic [5:0] mode;
    logic [5:0] pend;
    logic [5:0] pend_nxt;
    logic [5:0] edge_set;
    logic [5:0] clr;
    logic [5:0] mode_chg;
    logic [5:0] act;
    logic       mask_wr;
    logic       mode_wr;
    logic       pend_wr;
    logic       id_valid;
    logic [2:0] id_idx;
    logic       unused_wdata;

`ifdef INT_CTRL_SYNC_EN
    logic [5:0] sync_q1;
    logic [5:0] sync_q2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = irq_src;
`endif

    assign mask_wr  = we && (addr == 2'd0);
    assign mode_wr  = we && (addr == 2'd1);
    assign pend_wr  = we && (addr == 2'd2);

    assign edge_set = s & ~prev;
    assign clr      = pend_wr ? wdata[5:0] : 6'd0;
    assign mode_chg = mode_wr ? (wdata[5:0] ^ mode) : 6'd0;

    // Edge bits: set beats clear. Level bits track s. A mode flip clears the bit.
    assign pend_nxt = ((mode & (edge_set | (pend & ~clr))) | (~mode & s))
                      & ~mode_chg & SRC_EN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev  <= '0;
            mask  <= '0;
            mode  <= '0;
            pend  <= '0;
            HWInt <= '0;
        end else begin
            prev  <= s;
            pend  <= pend_nxt;
            HWInt <= pend & mask & SRC_EN;
            if (mask_wr) mask <= wdata[5:0];
            if (mode_wr) mode <= wdata[5:0];
        end
    end

    assign act = pend & mask & SRC_EN;

    // Lowest index wins, so scan from the top and let lower hits overwrite.
    always_comb begin
        id_valid = |act;
        id_idx   = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (act[i]) id_idx = 3'(i);
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0: rdata = {26'd0, mask};
            2'd1: rdata = {26'd0, mode};
            2'd2: rdata = {26'd0, pend};
            2'd3: rdata = {id_valid, 28'd0, id_idx};
            default: rdata = 32'd0;
        endcase
    end

    assign unused_wdata = ^wdata[31:6];

endmodule
